// File: rtl/clock_display_scan.sv
// Multiplexed 6-digit HH.MM.SS display driver for a common-anode 7-seg module.
// Fields are snapshotted once per frame and converted to BCD by repeated subtraction.
module clock_display_scan #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int SCAN_HZ  = 1000,
   parameter int BLINK_HZ = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] hours,
   input  logic [7:0] minutes,
   input  logic [7:0] seconds,
   input  logic       set_mod,
   input  logic [2:0] pos,
   output logic [7:0] an,
   output logic [7:0] seg
);
   // state   | meaning
   // S_IDLE  | waiting for the frame-start snapshot
   // S_LOAD  | fetch the selected field into the remainder register
   // S_SUB   | subtract 10 per clock, counting tens
   // S_NEXT  | store the field's digits, advance sec -> min -> hr
   // S_COMMIT| copy staged digits to the display registers
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SUB, S_NEXT, S_COMMIT} conv_state_t;

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int HB  = CLK_HZ / (2 * BLINK_HZ);
   localparam int DW  = $clog2(DIV);
   localparam int HW  = $clog2(HB);
   localparam logic [3:0] DASH = 4'hF;

   logic [DW-1:0]     tick_cnt_q;
   logic [2:0]        idx_q;
   logic [7:0]        an_q, seg_q;
   logic              tick_w;
   logic [3:0]        digit_w;
   logic [6:0]        code_w;

   conv_state_t       state_q, state_d;
   logic [2:0][7:0]   snap_q, snap_d;
   logic [1:0]        fsel_q, fsel_d;
   logic [7:0]        rem_q, rem_d;
   logic [3:0]        tens_q, tens_d;
   logic              dash_q, dash_d;
   logic [5:0][3:0]   stg_q, stg_d;
   logic [5:0][3:0]   disp_q, disp_d;

   logic [2:0]        pos_q;
   logic [HW-1:0]     blink_cnt_q;
   logic              phase_q;
   logic [7:0]        blank_w;

   assign tick_w  = (tick_cnt_q == DW'(DIV - 1));
   assign digit_w = disp_q[idx_q];

   always_comb begin
      case (digit_w)
         4'd0:    code_w = 7'h40;
         4'd1:    code_w = 7'h79;
         4'd2:    code_w = 7'h24;
         4'd3:    code_w = 7'h30;
         4'd4:    code_w = 7'h19;
         4'd5:    code_w = 7'h12;
         4'd6:    code_w = 7'h02;
         4'd7:    code_w = 7'h78;
         4'd8:    code_w = 7'h00;
         4'd9:    code_w = 7'h10;
         default: code_w = 7'h3F;
      endcase
   end

   // an/seg show the digit at idx_q, then idx_q moves on to the next one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt_q <= '0;
         idx_q      <= 3'd0;
         an_q       <= 8'hFF;
         seg_q      <= 8'hFF;
      end else if (tick_w) begin
         tick_cnt_q <= '0;
         idx_q      <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
         an_q       <= ~(8'd1 << idx_q);
         seg_q      <= {~((idx_q == 3'd2) || (idx_q == 3'd4)), code_w};
      end else begin
         tick_cnt_q <= tick_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         snap_q  <= '0;
         fsel_q  <= 2'd0;
         rem_q   <= 8'd0;
         tens_q  <= 4'd0;
         dash_q  <= 1'b0;
         stg_q   <= '0;
         disp_q  <= '0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         fsel_q  <= fsel_d;
         rem_q   <= rem_d;
         tens_q  <= tens_d;
         dash_q  <= dash_d;
         stg_q   <= stg_d;
         disp_q  <= disp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      fsel_d  = fsel_q;
      rem_d   = rem_q;
      tens_d  = tens_q;
      dash_d  = dash_q;
      stg_d   = stg_q;
      disp_d  = disp_q;
      case (state_q)
         S_IDLE: begin
            if (tick_w && (idx_q == 3'd5)) begin
               snap_d  = {hours, minutes, seconds};
               fsel_d  = 2'd0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            rem_d   = snap_q[fsel_q];
            tens_d  = 4'd0;
            dash_d  = (snap_q[fsel_q] >= 8'd100);
            state_d = (snap_q[fsel_q] >= 8'd100) ? S_NEXT : S_SUB;
         end
         S_SUB: begin
            if (rem_q >= 8'd10) begin
               rem_d  = rem_q - 8'd10;
               tens_d = tens_q + 4'd1;
            end else begin
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            stg_d[{fsel_q, 1'b0}] = dash_q ? DASH : rem_q[3:0];
            stg_d[{fsel_q, 1'b1}] = dash_q ? DASH : tens_q;
            if (fsel_q == 2'd2) begin
               state_d = S_COMMIT;
            end else begin
               fsel_d  = fsel_q + 2'd1;
               state_d = S_LOAD;
            end
         end
         S_COMMIT: begin
            disp_d  = stg_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // a cursor move restarts the blink so the new digit is seen at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_q       <= 3'd0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else begin
         pos_q <= pos;
         if (!set_mod || (pos != pos_q)) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
         end else if (blink_cnt_q == HW'(HB - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      blank_w = 8'h00;
      if (phase_q && (pos_q <= 3'd5))
         blank_w = 8'd1 << pos_q;
   end

   assign an  = an_q | blank_w;
   assign seg = seg_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan at DIV=10 clocks per digit, HB=100 clocks.
// Outputs are sampled on the falling edge; expected codes are hand-derived.
module tb_clock_display_scan;
   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] hours, minutes, seconds;
   logic       set_mod;
   logic [2:0] pos;
   logic [7:0] an, seg;

   int n_cmp = 0;
   int n_err = 0;

   clock_display_scan #(.CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(5)) dut (
      .clk     (clk),
      .reset   (reset),
      .hours   (hours),
      .minutes (minutes),
      .seconds (seconds),
      .set_mod (set_mod),
      .pos     (pos),
      .an      (an),
      .seg     (seg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // wait for a fresh appearance of the given anode pattern
   task automatic wait_an(input logic [7:0] target, input string tag);
      bit left = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (!left) begin
            if (an !== target) left = 1;
         end else if (an === target) begin
            return;
         end
      end
      check({tag, "_timeout"}, an, target);
   endtask

   logic [7:0] exp_an  [6] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
   logic [7:0] exp_seg [6] = '{8'hF8, 8'hC0, 8'h10, 8'h92, 8'h30, 8'hA4};

   initial begin
      int vis, hid, ff_cnt;
      reset = 1'b1; hours = 8'd23; minutes = 8'd59; seconds = 8'd7;
      set_mod = 1'b0; pos = 3'd7;
      repeat (3) @(negedge clk);
      check("rst_an", an, 8'hFF);
      check("rst_seg", seg, 8'hFF);

      // reset while digit 3 is lit, then time the first tick after release
      reset = 1'b0;
      wait_an(8'hF7, "reach_idx3");
      #1 reset = 1'b1;
      #1;
      check("midrst_an", an, 8'hFF);
      check("midrst_seg", seg, 8'hFF);
      @(negedge clk);
      reset = 1'b0;
      repeat (9) @(negedge clk);
      check("hold_an", an, 8'hFF);
      @(negedge clk);
      check("first_tick_an", an, 8'hFE);
      check("first_tick_seg", seg, 8'hC0);

      // 23:59:07 across a full steady frame
      wait_an(8'hFE, "frame2");
      wait_an(8'hFE, "frame3");
      for (int i = 0; i < 6; i++) begin
         check($sformatf("scan_an%0d", i), an, exp_an[i]);
         check($sformatf("scan_seg%0d", i), seg, exp_seg[i]);
         if (i < 5) repeat (10) @(negedge clk);
      end

      // mid-frame change is held off until a later frame
      wait_an(8'hFD, "f4_idx1");
      minutes = 8'd58;
      seconds = 8'd8;
      wait_an(8'hFB, "f4_idx2");
      check("midframe_min", seg, 8'h10);
      wait_an(8'hFE, "f5");
      wait_an(8'hFE, "f6");
      check("new_sec", seg, 8'h80);
      wait_an(8'hFB, "f6_idx2");
      check("new_min", seg, 8'h00);

      // out-of-range minutes show dashes
      minutes = 8'd100;
      wait_an(8'hFE, "f7");
      wait_an(8'hFE, "f8");
      check("dash_sec", seg, 8'h80);
      wait_an(8'hFB, "dash_i2");
      check("dash_min_lo", seg, 8'h3F);
      wait_an(8'hF7, "dash_i3");
      check("dash_min_hi", seg, 8'hBF);
      wait_an(8'hEF, "dash_i4");
      check("dash_hr_lo", seg, 8'h30);
      wait_an(8'hDF, "dash_i5");
      check("dash_hr_hi", seg, 8'hA4);

      // blink on digit 3: visible 100 clocks, hidden 100 clocks
      set_mod = 1'b1;
      pos = 3'd3;
      vis = 0; hid = 0;
      for (int k = 1; k <= 350; k++) begin
         @(negedge clk);
         if (k >= 3 && k <= 98 && an[3] == 1'b0) vis++;
         if (k >= 103 && k <= 198 && an[3] == 1'b0) hid++;
      end
      check("blink_vis3", (vis > 0), 1);
      check("blink_hid3", hid, 0);

      // cursor moves during the hidden phase
      pos = 3'd4;
      vis = 0; hid = 0;
      for (int j = 1; j <= 198; j++) begin
         @(negedge clk);
         if (j >= 3 && j <= 98 && an[4] == 1'b0) vis++;
         if (j >= 103 && j <= 198 && an[4] == 1'b0) hid++;
      end
      check("move_vis4", (vis > 0), 1);
      check("move_hid4", hid, 0);

      // no cursor: nothing is ever blanked
      pos = 3'd6;
      ff_cnt = 0;
      for (int j = 0; j < 400; j++) begin
         @(negedge clk);
         if (an == 8'hFF) ff_cnt++;
      end
      check("nocursor_blank", ff_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
